// File: rtl/cp0_multiport.sv
// Multi-port CP0 register file: Count/Compare timer, interrupt synchroniser, exception state.
// Define CP0_LLBIT_EN to add the LL bit (ll_set input, llbit output, register 17).
module cp0_multiport #(
    parameter int unsigned NW         = 2,
    parameter int unsigned NR         = 2,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NW-1:0]    i_cwe,
    input  logic [NW*5-1:0]  i_cwaddr,
    input  logic [NW*32-1:0] i_cwdata,
    input  logic [NR*5-1:0]  i_ra,
    output logic [NR*32-1:0] o_rd,
    input  logic             i_exc_valid,
    input  logic [4:0]       i_exc_code,
    input  logic [31:0]      i_exc_pc,
    input  logic             i_exc_in_delay_slot,
    input  logic [31:0]      i_exc_badvaddr,
    input  logic             i_is_eret,
    input  logic [5:0]       i_hw_int,
`ifdef CP0_LLBIT_EN
    input  logic             i_ll_set,
    output logic             o_llbit,
`endif
    output logic             o_int_pending,
    output logic             o_timer_interrupt,
    output logic [31:0]      o_cp0_status,
    output logic [31:0]      o_cp0_cause,
    output logic [31:0]      o_cp0_epc
);

    localparam int unsigned PRESC_W      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0]        r_badvaddr, r_count, r_compare, r_status, r_epc;
    logic               r_bd, r_ti, r_int_pending;
    logic [1:0]         r_ip_sw;
    logic [4:0]         r_exccode;
    logic [PRESC_W-1:0] r_presc;
    logic [5:0]         r_sync1, r_sync2;

    logic [31:0]        w_badvaddr_d, w_count_d, w_compare_d, w_status_d, w_epc_d;
    logic               w_bd_d, w_ti_d, w_int_pending_d, w_compare_wr, w_presc_wrap;
    logic [1:0]         w_ip_sw_d;
    logic [4:0]         w_exccode_d;
    logic [PRESC_W-1:0] w_presc_d;
    logic [7:0]         w_ip;
    logic [31:0]        w_cause;

    // Hardware IP bits come straight from the second synchroniser flop.
    assign w_ip    = {r_sync2[5] | r_ti, r_sync2[4:0], r_ip_sw};
    assign w_cause = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b00};

    assign w_int_pending_d = r_status[0] & ~r_status[1] & ~r_status[2] &
                             (|(w_ip & r_status[15:8]));

    always_comb begin
        w_badvaddr_d = r_badvaddr;
        w_compare_d  = r_compare;
        w_status_d   = r_status;
        w_epc_d      = r_epc;
        w_bd_d       = r_bd;
        w_ip_sw_d    = r_ip_sw;
        w_exccode_d  = r_exccode;
        w_compare_wr = 1'b0;
        w_presc_wrap = (r_presc == PRESC_W'(COUNT_DIV - 1));
        w_count_d    = w_presc_wrap ? r_count + 32'd1 : r_count;
        w_presc_d    = w_presc_wrap ? '0 : r_presc + PRESC_W'(1);

        if (i_exc_valid) begin
            if (!r_status[1]) begin
                w_bd_d  = i_exc_in_delay_slot;
                w_epc_d = i_exc_in_delay_slot ? i_exc_pc - 32'd4 : i_exc_pc;
            end
            w_exccode_d   = i_exc_code;
            w_status_d[1] = 1'b1;
            if (i_exc_code == 5'd4 || i_exc_code == 5'd5) begin
                w_badvaddr_d = i_exc_badvaddr;
            end
        end else begin
            // Highest index first so the lowest index lands last and wins.
            for (int i = int'(NW) - 1; i >= 0; i--) begin
                if (i_cwe[i]) begin
                    case (i_cwaddr[i*5 +: 5])
                        5'd9: begin
                            w_count_d = i_cwdata[i*32 +: 32];
                            w_presc_d = '0;
                        end
                        5'd11: begin
                            w_compare_d  = i_cwdata[i*32 +: 32];
                            w_compare_wr = 1'b1;
                        end
                        5'd12: w_status_d = (w_status_d & ~STATUS_WMASK) |
                                            (i_cwdata[i*32 +: 32] & STATUS_WMASK);
                        5'd13: w_ip_sw_d  = i_cwdata[i*32 + 8 +: 2];
                        5'd14: w_epc_d    = i_cwdata[i*32 +: 32];
                        default: ;
                    endcase
                end
            end
            if (i_is_eret) begin
                if (r_status[2]) w_status_d[2] = 1'b0;
                else             w_status_d[1] = 1'b0;
            end
        end

        w_ti_d = w_compare_wr ? 1'b0 : (r_ti | (w_count_d == r_compare));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_badvaddr    <= '0;
            r_count       <= '0;
            r_compare     <= '0;
            r_status      <= STATUS_RESET;
            r_epc         <= '0;
            r_bd          <= 1'b0;
            r_ti          <= 1'b0;
            r_ip_sw       <= '0;
            r_exccode     <= '0;
            r_presc       <= '0;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_int_pending <= 1'b0;
        end else begin
            r_badvaddr    <= w_badvaddr_d;
            r_count       <= w_count_d;
            r_compare     <= w_compare_d;
            r_status      <= w_status_d;
            r_epc         <= w_epc_d;
            r_bd          <= w_bd_d;
            r_ti          <= w_ti_d;
            r_ip_sw       <= w_ip_sw_d;
            r_exccode     <= w_exccode_d;
            r_presc       <= w_presc_d;
            r_sync1       <= i_hw_int;
            r_sync2       <= r_sync1;
            r_int_pending <= w_int_pending_d;
        end
    end

`ifdef CP0_LLBIT_EN
    logic r_llbit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_llbit <= 1'b0;
        end else if (i_exc_valid || i_is_eret) begin
            r_llbit <= 1'b0;
        end else if (i_ll_set) begin
            r_llbit <= 1'b1;
        end
    end

    assign o_llbit = r_llbit;
`endif

    always_comb begin
        o_rd = '0;
        for (int p = 0; p < int'(NR); p++) begin
            case (i_ra[p*5 +: 5])
                5'd8:  o_rd[p*32 +: 32] = r_badvaddr;
                5'd9:  o_rd[p*32 +: 32] = r_count;
                5'd11: o_rd[p*32 +: 32] = r_compare;
                5'd12: o_rd[p*32 +: 32] = r_status;
                5'd13: o_rd[p*32 +: 32] = w_cause;
                5'd14: o_rd[p*32 +: 32] = r_epc;
                5'd16: o_rd[p*32 +: 32] = CONFIG_VAL;
`ifdef CP0_LLBIT_EN
                5'd17: o_rd[p*32 +: 32] = {31'b0, r_llbit};
`endif
                default: o_rd[p*32 +: 32] = '0;
            endcase
        end
    end

    assign o_int_pending     = r_int_pending;
    assign o_timer_interrupt = r_ti;
    assign o_cp0_status      = r_status;
    assign o_cp0_cause       = w_cause;
    assign o_cp0_epc         = r_epc;

endmodule

// File: tb/tb_cp0_multiport.sv
// Self-checking bench for cp0_multiport: directed steps plus random traffic against a
// cycle-level reference model of the architectural CP0 state.
module tb_cp0_multiport;

    localparam int unsigned NW  = 2;
    localparam int unsigned NR  = 2;
    localparam int unsigned DIV = 2;
    localparam logic [31:0] CFG = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NW-1:0]    cwe = '0;
    logic [NW*5-1:0]  cwaddr = '0;
    logic [NW*32-1:0] cwdata = '0;
    logic [NR*5-1:0]  ra = '0;
    logic [NR*32-1:0] rd;
    logic             exc_valid = 1'b0;
    logic [4:0]       exc_code = '0;
    logic [31:0]      exc_pc = '0;
    logic             exc_ds = 1'b0;
    logic [31:0]      exc_bva = '0;
    logic             is_eret = 1'b0;
    logic [5:0]       hw_int = '0;
    logic             int_pending, timer_int;
    logic [31:0]      st_o, cause_o, epc_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_multiport #(
        .NW(NW), .NR(NR), .COUNT_DIV(DIV), .CONFIG_VAL(CFG)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_cwe(cwe), .i_cwaddr(cwaddr), .i_cwdata(cwdata),
        .i_ra(ra), .o_rd(rd), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
        .i_exc_pc(exc_pc), .i_exc_in_delay_slot(exc_ds), .i_exc_badvaddr(exc_bva),
        .i_is_eret(is_eret), .i_hw_int(hw_int), .o_int_pending(int_pending),
        .o_timer_interrupt(timer_int), .o_cp0_status(st_o), .o_cp0_cause(cause_o),
        .o_cp0_epc(epc_o)
    );

    // Reference model: architectural state plus the two-cycle interrupt line history.
    logic [31:0] m_count, m_compare, m_status, m_epc, m_badv;
    logic        m_bd, m_ti, m_pend;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic [5:0]  m_hist [2];
    int unsigned m_since_tick;

    function automatic logic [7:0] m_ip();
        return {m_hist[1][5] | m_ti, m_hist[1][4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_code) << 2);
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd16:   return CFG;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_epc = 0; m_badv = 0;
        m_bd = 0; m_ti = 0; m_pend = 0; m_ipsw = 0; m_code = 0;
        m_hist[0] = 0; m_hist[1] = 0; m_since_tick = 0;
    endtask

    task automatic model_step();
        logic [31:0] cnt, cmp, st, epc, bva;
        logic        bd, cmp_wr, pend;
        logic [1:0]  ipsw;
        logic [4:0]  code, a;
        logic [31:0] d;
        int unsigned tick;
        bit          claimed [32];
        pend = m_status[0] && !m_status[1] && !m_status[2] && ((m_ip() & m_status[15:8]) != 0);
        cnt = m_count; cmp = m_compare; st = m_status; epc = m_epc; bva = m_badv;
        bd = m_bd; ipsw = m_ipsw; code = m_code; cmp_wr = 0;
        for (int k = 0; k < 32; k++) claimed[k] = 0;
        if (m_since_tick + 1 == DIV) begin
            cnt = cnt + 1;
            tick = 0;
        end else begin
            tick = m_since_tick + 1;
        end
        if (exc_valid) begin
            if (!m_status[1]) begin
                bd  = exc_ds;
                epc = exc_ds ? exc_pc - 4 : exc_pc;
            end
            code = exc_code;
            st[1] = 1'b1;
            if (exc_code == 4 || exc_code == 5) bva = exc_bva;
        end else begin
            // First (lowest) port to touch an address owns it this cycle.
            for (int p = 0; p < int'(NW); p++) begin
                a = cwaddr[p*5 +: 5];
                d = cwdata[p*32 +: 32];
                if (cwe[p] && !claimed[a]) begin
                    claimed[a] = 1;
                    case (a)
                        5'd9:  begin cnt = d; tick = 0; end
                        5'd11: begin cmp = d; cmp_wr = 1; end
                        5'd12: begin
                            st[15:8] = d[15:8];
                            st[1:0]  = d[1:0];
                        end
                        5'd13: ipsw = d[9:8];
                        5'd14: epc = d;
                        default: ;
                    endcase
                end
            end
            if (is_eret) begin
                if (m_status[2]) st[2] = 1'b0;
                else             st[1] = 1'b0;
            end
        end
        m_ti = cmp_wr ? 1'b0 : (m_ti || cnt == m_compare);
        m_count = cnt; m_compare = cmp; m_status = st; m_epc = epc; m_badv = bva;
        m_bd = bd; m_ipsw = ipsw; m_code = code; m_since_tick = tick; m_pend = pend;
        m_hist[1] = m_hist[0];
        m_hist[0] = hw_int;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cwe = '0; exc_valid = 0; is_eret = 0;
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        cwe = en;
        cwaddr = {a1, a0};
        cwdata = {d1, d0};
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
        ra[4:0] = a;
        #1;
        v = rd[31:0];
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 5'd8;   1: return 5'd9;   2: return 5'd11;  3: return 5'd12;
            4: return 5'd13;  5: return 5'd14;  6: return 5'd16;  7: return 5'd17;
            8: return 5'd0;   default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic check_all();
        logic [4:0] a0, a1;
        a0 = pick_addr();
        a1 = pick_addr();
        ra = {a1, a0};
        #1;
        chk($sformatf("rd0[%0d]", a0), rd[31:0], m_read(a0));
        chk($sformatf("rd1[%0d]", a1), rd[63:32], m_read(a1));
        chk("status", st_o, m_status);
        chk("cause", cause_o, m_cause());
        chk("epc", epc_o, m_epc);
        chk("int_pending", 32'(int_pending), 32'(m_pend));
        chk("timer_int", 32'(timer_int), 32'(m_ti));
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        model_reset();
        #1 rst = 1;
        @(posedge clk);
        #1;
        read_reg(5'd12, v); chk("reset_status", v, 32'h0040_0000);
        read_reg(5'd16, v); chk("reset_config", v, CFG);
        read_reg(5'd9, v);  chk("reset_count", v, 32'h0);
        chk("reset_int_pending", 32'(int_pending), 32'h0);
        rst = 0;
        check_all();

        // Timer: Compare=10 and Count=0 in one cycle, then wait for TI.
        wr(2'b11, 5'd11, 32'd10, 5'd9, 32'd0);
        step(); idle();
        chk("ti_cleared", 32'(timer_int), 32'h0);
        n = 0;
        while (n < 40 && !timer_int) begin
            step(); n++;
            check_all();
        end
        chk("ti_rise", 32'(timer_int), 32'h1);
        chk("ti_latency", 32'(n), 32'd20);
        read_reg(5'd9, v); chk("count_at_ti", v, 32'd10);
        chk("cause_ti", 32'(cause_o[30]), 32'h1);
        wr(2'b01, 5'd11, 32'd50, 5'd0, 32'd0);
        step(); idle();
        chk("ti_after_cmp_wr", 32'(timer_int), 32'h0);
        check_all();

        // Same-address conflict, then a status write on port 1.
        wr(2'b11, 5'd14, 32'h1111, 5'd14, 32'h2222);
        step(); idle();
        chk("epc_conflict", epc_o, 32'h1111);
        wr(2'b11, 5'd8, 32'hDEAD, 5'd12, 32'h0000_FF01);
        step(); idle();
        chk("status_im_ie", st_o, 32'h0040_FF01);
        read_reg(5'd8, v); chk("badvaddr_ro", v, 32'h0);
        check_all();

        // Hardware interrupt through the synchroniser.
        wr(2'b01, 5'd12, 32'h0000_0401, 5'd0, 32'h0);
        step(); idle();
        hw_int = 6'b000001;
        step(); hw_int = 0;
        chk("ip2_after1", 32'(cause_o[10]), 32'h0);
        step();
        chk("ip2_after2", 32'(cause_o[10]), 32'h1);
        step();
        chk("int_pending_rise", 32'(int_pending), 32'h1);
        check_all();
        hw_int = 6'b000001;
        step(); step(); step();
        check_all();
        wr(2'b01, 5'd12, 32'h0000_0403, 5'd0, 32'h0);
        step(); idle();
        step();
        chk("int_pending_exl", 32'(int_pending), 32'h0);
        check_all();
        hw_int = 0;
        wr(2'b01, 5'd12, 32'h0000_0401, 5'd0, 32'h0);
        step(); idle();

        // Exceptions and ERET.
        exc_valid = 1; exc_code = 5'd4; exc_ds = 1;
        exc_pc = 32'hBFC0_0104; exc_bva = 32'h13;
        wr(2'b01, 5'd14, 32'h5555, 5'd0, 32'h0);
        step(); idle();
        chk("exc_epc", epc_o, 32'hBFC0_0100);
        chk("exc_bd", 32'(cause_o[31]), 32'h1);
        chk("exc_exl", 32'(st_o[1]), 32'h1);
        chk("exc_code", 32'(cause_o[6:2]), 32'd4);
        read_reg(5'd8, v); chk("exc_badvaddr", v, 32'h13);
        check_all();
        exc_valid = 1; exc_code = 5'd0; exc_ds = 0; exc_pc = 32'h1234; exc_bva = 32'h77;
        step(); idle();
        chk("exc2_epc", epc_o, 32'hBFC0_0100);
        read_reg(5'd8, v); chk("exc2_badvaddr", v, 32'h13);
        is_eret = 1;
        step(); idle();
        chk("eret_exl", 32'(st_o[1]), 32'h0);
        exc_valid = 1; is_eret = 1; exc_code = 5'd8; exc_pc = 32'h400;
        step(); idle();
        chk("exc_eret_exl", 32'(st_o[1]), 32'h1);
        chk("exc_eret_epc", epc_o, 32'h400);
        check_all();

        // Count wraps from all-ones to zero.
        wr(2'b01, 5'd9, 32'hFFFF_FFFF, 5'd0, 32'h0);
        step(); idle();
        read_reg(5'd9, v); chk("count_max", v, 32'hFFFF_FFFF);
        step(); step();
        read_reg(5'd9, v); chk("count_wrap", v, 32'h0);
        check_all();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [4:0]  a0, a1;
            logic [31:0] d0, d1;
            a0 = pick_addr(); a1 = pick_addr();
            d0 = $urandom; d1 = $urandom;
            if (a0 == 5'd9 && $urandom_range(0, 2) == 0) d0 = m_compare - $urandom_range(0, 2);
            if (a1 == 5'd9 && $urandom_range(0, 2) == 0) d1 = m_compare - $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) wr(2'($urandom_range(0, 3)), a0, d0, a1, d1);
            else cwe = '0;
            exc_valid = ($urandom_range(0, 15) == 0);
            exc_code  = ($urandom_range(0, 1) == 0) ? 5'(4 + $urandom_range(0, 1))
                                                    : 5'($urandom_range(0, 31));
            exc_ds    = 1'($urandom_range(0, 1));
            exc_pc    = $urandom;
            exc_bva   = $urandom;
            is_eret   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom_range(0, 63));
            step();
            check_all();
        end
        idle();

        // Asynchronous reset in mid-count, away from any clock edge.
        step(); step(); step();
        #2 rst = 1;
        model_reset();
        read_reg(5'd9, v); chk("async_reset_count", v, 32'h0);
        chk("async_reset_status", st_o, 32'h0040_0000);
        chk("async_reset_int", 32'(int_pending), 32'h0);
        #1 rst = 0;
        hw_int = 0;
        step();
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
